// File: rtl/surf_trig_pkg.sv
// rtl/surf_trig_pkg.sv - shared constants and beam helpers for surf_trig_gen_v4
// Purpose: trigger word field layout, address/drop widths, popcount and
//          lowest-set-index helpers on a beam vector zero-padded to 256 bits.
// Ports:   none (package).
package surf_trig_pkg;

   localparam int ADDR_W    = 12;
   localparam int DROP_W    = 16;
   localparam int MAX_BEAMS = 256;

   localparam logic [1:0] TRIG_HDR = 2'b10;

   // Trigger word layout; bits [17:16] are always zero.
   localparam int HDR_MSB  = 31;
   localparam int HDR_LSB  = 30;
   localparam int ADDR_MSB = 29;
   localparam int ADDR_LSB = 18;
   localparam int CNT_MSB  = 15;
   localparam int CNT_LSB  = 8;
   localparam int IDX_MSB  = 7;
   localparam int IDX_LSB  = 0;

   // Number of set bits, saturated at 255.
   function automatic logic [7:0] popcount_sat(input logic [MAX_BEAMS-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < MAX_BEAMS; i++) begin
         if (v[i]) cnt++;
      end
      if (cnt > 255) cnt = 255;
      return cnt[7:0];
   endfunction

   // Index of the lowest set bit; zero when nothing is set.
   function automatic logic [7:0] lowest_index(input logic [MAX_BEAMS-1:0] v);
      logic [7:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_BEAMS; i++) begin
         if (v[i] && !found) begin
            idx   = i[7:0];
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/surf_trig_gen_v4_fifo.sv
// rtl/surf_trig_gen_v4_fifo.sv - first-word-fall-through trigger word FIFO
// Purpose: synchronous FWFT FIFO, WIDTH x DEPTH, asynchronous active-high reset.
// Ports:   clk, rst; wr_en/wr_data write side (ignored when full);
//          rd_en/rd_data read side (rd_data is the head word, zero when empty);
//          full, empty status flags.
module trig_word_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // One extra pointer bit separates full from empty when the indices match.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/surf_trig_gen_v4.sv
// rtl/surf_trig_gen_v4.sv - masked, holdoff-limited beam trigger word generator
// Purpose: masks per-beam triggers with a double-buffered mask, enforces a
//          holdoff between accepts, stamps each accept with run address and
//          beam metadata and queues it as a 32-bit stream word.
// Ports:   ifclk, gen_rst_i (async, active-high);
//          trig_i per-beam triggers;
//          mask_dat_i/mask_idx_i/mask_wr_i shadow mask write, mask_update_i copy;
//          holdoff_i dead cycles after an accept;
//          offset_i/runrst_i/runstop_i run control;
//          trig_tdata/trig_tvalid/trig_tready output stream;
//          dropped_o saturating drop count, running_o run active.
module surf_trig_gen_v4
   import surf_trig_pkg::*;
#(
   parameter  int NBEAMS     = 48,
   parameter  int FIFO_DEPTH = 16,
   parameter  int HOLDOFF_W  = 8,
   localparam int MWORDS     = (NBEAMS + 31) / 32,
   localparam int IDX_W      = (MWORDS > 1) ? $clog2(MWORDS) : 1
)(
   input  logic                 ifclk,
   input  logic                 gen_rst_i,
   input  logic [NBEAMS-1:0]    trig_i,
   input  logic [31:0]          mask_dat_i,
   input  logic [IDX_W-1:0]     mask_idx_i,
   input  logic                 mask_wr_i,
   input  logic                 mask_update_i,
   input  logic [HOLDOFF_W-1:0] holdoff_i,
   input  logic [ADDR_W-1:0]    offset_i,
   input  logic                 runrst_i,
   input  logic                 runstop_i,
   output logic [31:0]          trig_tdata,
   output logic                 trig_tvalid,
   input  logic                 trig_tready,
   output logic [DROP_W-1:0]    dropped_o,
   output logic                 running_o
);

   logic [NBEAMS-1:0]    shadow_mask;
   logic [NBEAMS-1:0]    active_mask;
   logic [NBEAMS-1:0]    beams_q;
   logic                 hit_q;
   logic [15:0]          meta_q;
   logic [HOLDOFF_W-1:0] holdoff_cnt;
   logic                 running;
   logic [ADDR_W-1:0]    offset_q;
   logic [ADDR_W-1:0]    cur_addr;
   logic                 accept;
   logic [31:0]          word_d;
   logic [31:0]          word_q;
   logic                 push_q;
   logic [DROP_W-1:0]    dropped;
   logic                 fifo_full;
   logic                 fifo_empty;

   // Mask banks. The active copy takes the shadow value from before any
   // write in the same cycle. Indices past the last word match no beam.
   always_ff @(posedge ifclk or posedge gen_rst_i) begin
      if (gen_rst_i) begin
         shadow_mask <= '1;
         active_mask <= '1;
      end else begin
         if (mask_update_i) active_mask <= shadow_mask;
         if (mask_wr_i) begin
            for (int b = 0; b < NBEAMS; b++) begin
               if ((b >> 5) == int'(mask_idx_i)) shadow_mask[b] <= mask_dat_i[b[4:0]];
            end
         end
      end
   end

   // Stages 0 and 1: masked beam capture, then hit flag and metadata.
   always_ff @(posedge ifclk or posedge gen_rst_i) begin
      if (gen_rst_i) begin
         beams_q <= '0;
         hit_q   <= 1'b0;
         meta_q  <= '0;
      end else begin
         beams_q <= trig_i & ~active_mask;
         hit_q   <= |beams_q;
         meta_q  <= {popcount_sat(MAX_BEAMS'(beams_q)), lowest_index(MAX_BEAMS'(beams_q))};
      end
   end

   assign accept = hit_q && running && (holdoff_cnt == '0);

   always_comb begin
      word_d                    = '0;
      word_d[HDR_MSB:HDR_LSB]   = TRIG_HDR;
      word_d[ADDR_MSB:ADDR_LSB] = cur_addr + offset_q;
      word_d[CNT_MSB:CNT_LSB]   = meta_q[15:8];
      word_d[IDX_MSB:IDX_LSB]   = meta_q[7:0];
   end

   // Stage 2: accept, holdoff countdown and word capture.
   always_ff @(posedge ifclk or posedge gen_rst_i) begin
      if (gen_rst_i) begin
         holdoff_cnt <= '0;
         word_q      <= '0;
         push_q      <= 1'b0;
      end else begin
         push_q <= accept;
         if (accept) begin
            holdoff_cnt <= holdoff_i;
            word_q      <= word_d;
         end else if (holdoff_cnt != '0) begin
            holdoff_cnt <= holdoff_cnt - 1'b1;
         end
      end
   end

   // Run control. The address counter sits at 1 while stopped so the first
   // running cycle after a start stamps address 1.
   always_ff @(posedge ifclk or posedge gen_rst_i) begin
      if (gen_rst_i) begin
         running  <= 1'b0;
         offset_q <= '0;
         cur_addr <= ADDR_W'(1);
      end else begin
         if (runrst_i) begin
            running  <= 1'b1;
            offset_q <= offset_i;
         end else if (runstop_i) begin
            running <= 1'b0;
         end
         cur_addr <= running ? cur_addr + 1'b1 : ADDR_W'(1);
      end
   end

   // A push into a full FIFO is lost; fullness is judged before any pop.
   always_ff @(posedge ifclk or posedge gen_rst_i) begin
      if (gen_rst_i) begin
         dropped <= '0;
      end else if (runrst_i) begin
         dropped <= '0;
      end else if (push_q && fifo_full && (dropped != '1)) begin
         dropped <= dropped + 1'b1;
      end
   end

   trig_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (ifclk),
      .rst     (gen_rst_i),
      .wr_en   (push_q),
      .wr_data (word_q),
      .rd_en   (trig_tready),
      .rd_data (trig_tdata),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign trig_tvalid = !fifo_empty;
   assign dropped_o   = dropped;
   assign running_o   = running;

endmodule

// File: tb/tb_surf_trig_gen_v4.sv
// tb/tb_surf_trig_gen_v4.sv - self-checking bench for surf_trig_gen_v4
module tb_surf_trig_gen_v4;

   localparam int NB    = 48;
   localparam int DEPTH = 4;
   localparam int HW    = 8;

   logic          ifclk;
   logic          gen_rst_i;
   logic [NB-1:0] trig;
   logic [31:0]   mask_dat;
   logic [0:0]    mask_idx;
   logic          mask_wr;
   logic          mask_update;
   logic [HW-1:0] holdoff;
   logic [11:0]   offset;
   logic          runrst;
   logic          runstop;
   logic [31:0]   trig_tdata;
   logic          trig_tvalid;
   logic          trig_tready;
   logic [15:0]   dropped_o;
   logic          running_o;

   surf_trig_gen_v4 #(.NBEAMS(NB), .FIFO_DEPTH(DEPTH), .HOLDOFF_W(HW)) dut (
      .ifclk         (ifclk),
      .gen_rst_i     (gen_rst_i),
      .trig_i        (trig),
      .mask_dat_i    (mask_dat),
      .mask_idx_i    (mask_idx),
      .mask_wr_i     (mask_wr),
      .mask_update_i (mask_update),
      .holdoff_i     (holdoff),
      .offset_i      (offset),
      .runrst_i      (runrst),
      .runstop_i     (runstop),
      .trig_tdata    (trig_tdata),
      .trig_tvalid   (trig_tvalid),
      .trig_tready   (trig_tready),
      .dropped_o     (dropped_o),
      .running_o     (running_o)
   );

   initial begin
      ifclk = 1'b0;
      forever #5 ifclk = ~ifclk;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: whole-trigger view built from edge numbers.
   logic [NB-1:0] m_shadow, m_active, b1, b2;
   bit            m_run, m_has_acc, p_valid;
   int            m_run_edge, m_off, m_last_acc, m_last_hold, m_drop, n_edge;
   logic [31:0]   p_word;
   logic [31:0]   q[$];
   logic [31:0]   wq[$];

   function automatic logic [31:0] mk_word(input int addr, input logic [NB-1:0] b);
      int pc, idx;
      logic [11:0] a;
      logic [7:0]  pc8, idx8;
      pc  = 0;
      idx = -1;
      for (int i = 0; i < NB; i++) begin
         if (b[i]) begin
            pc++;
            if (idx < 0) idx = i;
         end
      end
      if (pc > 255) pc = 255;
      a    = addr[11:0];
      pc8  = pc[7:0];
      idx8 = idx[7:0];
      return {2'b10, a, 2'b00, pc8, idx8};
   endfunction

   task automatic model_reset();
      m_shadow = '1; m_active = '1; b1 = '0; b2 = '0;
      m_run = 0; m_has_acc = 0; p_valid = 0; p_word = '0;
      m_off = 0; m_drop = 0; m_run_edge = 0; m_last_acc = 0; m_last_hold = 0;
      q.delete();
   endtask

   task automatic model_step();
      bit            acc, full;
      logic [31:0]   w, junk;
      logic [NB-1:0] nxt_active;
      w   = '0;
      acc = (b2 != '0) && m_run && (!m_has_acc || (n_edge - m_last_acc) > m_last_hold);
      if (acc) w = mk_word(((n_edge - m_run_edge) + m_off) % 4096, b2);
      full = (q.size() >= DEPTH);
      if (trig_tready && q.size() > 0) junk = q.pop_front();
      if (p_valid) begin
         if (full) begin
            if (m_drop < 65535) m_drop++;
         end else q.push_back(p_word);
      end
      if (runrst) m_drop = 0;
      if (acc) begin
         m_last_acc  = n_edge;
         m_last_hold = int'(holdoff);
         m_has_acc   = 1;
      end
      p_valid = acc;
      p_word  = w;
      b2 = b1;
      b1 = trig & ~m_active;
      nxt_active = mask_update ? m_shadow : m_active;
      if (mask_wr) begin
         for (int b = 0; b < NB; b++) if (b / 32 == int'(mask_idx)) m_shadow[b] = mask_dat[b % 32];
      end
      m_active = nxt_active;
      if (runrst) begin
         if (!m_run) m_run_edge = n_edge;
         m_run = 1;
         m_off = int'(offset);
      end else if (runstop) m_run = 0;
      n_edge++;
   endtask

   task automatic tick();
      if (!gen_rst_i) model_step();
      @(posedge ifclk);
      #1;
      chk("tvalid", trig_tvalid, q.size() > 0);
      chk("tdata", trig_tdata, (q.size() > 0) ? q[0] : 32'h0);
      chk("dropped", dropped_o, m_drop);
      chk("running", running_o, m_run);
      runrst = 0; runstop = 0; mask_wr = 0; mask_update = 0;
   endtask

   task automatic obs_tick();
      if (trig_tvalid && trig_tready) wq.push_back(trig_tdata);
      tick();
   endtask

   task automatic write_mask(input logic [0:0] idx, input logic [31:0] d, input bit upd);
      mask_idx = idx; mask_dat = d; mask_wr = 1; mask_update = upd;
      tick();
   endtask

   task automatic update_mask();
      mask_update = 1;
      tick();
   endtask

   task automatic start_run(input logic [11:0] off);
      offset = off; runrst = 1;
      tick();
   endtask

   task automatic pulse(input logic [NB-1:0] t, input int hold);
      wq.delete();
      trig = t;
      repeat (hold) obs_tick();
      trig = '0;
      repeat (8) obs_tick();
   endtask

   typedef struct packed {
      logic [NB-1:0] t;
      logic [NB-1:0] m;
      logic [7:0]    pc;
      logic [7:0]    idx;
   } vec_t;

   vec_t        vt[6];
   logic [31:0] w0, w1, w2;
   logic [63:0] r;

   initial begin
      vt[0] = '{t: 48'h0000_0000_0020, m: 48'h0,              pc: 8'd1,  idx: 8'd5};
      vt[1] = '{t: 48'h0100_0000_0208, m: 48'h0,              pc: 8'd3,  idx: 8'd3};
      vt[2] = '{t: 48'h0100_0000_0208, m: 48'h0000_0000_0008, pc: 8'd2,  idx: 8'd9};
      vt[3] = '{t: 48'h8000_0000_0001, m: 48'h0000_0000_0001, pc: 8'd1,  idx: 8'd47};
      vt[4] = '{t: 48'hFFFF_FFFF_FFFF, m: 48'h0,              pc: 8'd48, idx: 8'd0};
      vt[5] = '{t: 48'h0002_8000_0000, m: 48'h0002_0000_0000, pc: 8'd1,  idx: 8'd31};

      gen_rst_i = 1; trig = '0; mask_dat = '0; mask_idx = '0; mask_wr = 0; mask_update = 0;
      holdoff = '0; offset = '0; runrst = 0; runstop = 0; trig_tready = 1;
      n_edge = 0;
      model_reset();
      #1;
      chk("reset_tvalid", trig_tvalid, 0);
      chk("reset_tdata", trig_tdata, 0);
      chk("reset_dropped", dropped_o, 0);
      chk("reset_running", running_o, 0);
      repeat (2) tick();
      gen_rst_i = 0;
      tick();

      // Table vectors: mask, run, single-cycle pulse, check metadata.
      for (int v = 0; v < 6; v++) begin
         write_mask(1'b0, vt[v].m[31:0], 0);
         write_mask(1'b1, {16'h0, vt[v].m[47:32]}, 0);
         update_mask();
         start_run(12'h010);
         pulse(vt[v].t, 1);
         w0 = (wq.size() > 0) ? wq[0] : 32'h0;
         chk($sformatf("vec%0d_count", v), wq.size(), 1);
         chk($sformatf("vec%0d_hdr", v), w0[31:30], 2'b10);
         chk($sformatf("vec%0d_pc", v), w0[15:8], vt[v].pc);
         chk($sformatf("vec%0d_idx", v), w0[7:0], vt[v].idx);
         if (v == 0) chk("vec0_addr", w0[29:18], 12'h013);
      end

      // Holdoff 7 with trigger held 20 cycles: three accepts, 8 apart.
      write_mask(1'b0, 32'h0, 0);
      write_mask(1'b1, 32'h0, 0);
      update_mask();
      holdoff = 8'd7;
      pulse(48'h1, 20);
      chk("holdoff_count", wq.size(), 3);
      w0 = (wq.size() > 0) ? wq[0] : 32'h0;
      w1 = (wq.size() > 1) ? wq[1] : 32'h0;
      w2 = (wq.size() > 2) ? wq[2] : 32'h0;
      chk("holdoff_gap1", (w1[29:18] - w0[29:18]) & 12'hFFF, 12'd8);
      chk("holdoff_gap2", (w2[29:18] - w1[29:18]) & 12'hFFF, 12'd8);

      // FIFO full with sink stalled: 6 accepts, 4 held, 2 dropped.
      holdoff = '0;
      trig_tready = 0;
      trig = 48'h1;
      repeat (6) tick();
      trig = '0;
      repeat (6) tick();
      chk("drop_count", dropped_o, 16'd2);
      chk("drop_tvalid_held", trig_tvalid, 1);
      trig_tready = 1;
      wq.delete();
      repeat (8) obs_tick();
      chk("drop_drained", wq.size(), 4);
      start_run(12'h010);
      chk("drop_cleared", dropped_o, 16'd0);

      // Update in the same cycle as a write uses the old shadow.
      write_mask(1'b0, 32'h20, 1);
      pulse(48'h20, 1);
      chk("same_cycle_update_words", wq.size(), 1);
      update_mask();
      pulse(48'h20, 1);
      chk("masked_beam_words", wq.size(), 0);

      // Stopped run produces nothing; simultaneous start/stop starts.
      runstop = 1;
      tick();
      pulse(48'h1, 3);
      chk("stopped_words", wq.size(), 0);
      runrst = 1; runstop = 1;
      tick();
      chk("rst_wins_running", running_o, 1);
      runstop = 1;
      tick();

      // Address wrap: offset 0xFFF plus first address 1 gives 0.
      trig = 48'h4;
      tick();
      trig = '0;
      start_run(12'hFFF);
      pulse('0, 1);
      w0 = (wq.size() > 0) ? wq[0] : 32'h0;
      chk("wrap_count", wq.size(), 1);
      chk("wrap_addr", w0[29:18], 12'h000);
      chk("wrap_idx", w0[7:0], 8'd2);

      // Randomised traffic against the model.
      start_run(12'($urandom));
      for (int c = 0; c < 400; c++) begin
         r = {$urandom(), $urandom()};
         trig = ($urandom_range(0, 7) == 0) ? r[47:0] & {$urandom(), $urandom()} : '0;
         trig_tready = ($urandom_range(0, 3) != 0);
         holdoff = 8'($urandom_range(0, 4));
         if ($urandom_range(0, 19) == 0) begin
            mask_wr = 1; mask_idx = 1'($urandom); mask_dat = $urandom() & $urandom() & $urandom();
         end
         if ($urandom_range(0, 24) == 0) mask_update = 1;
         if ($urandom_range(0, 59) == 0) begin runrst = 1; offset = 12'($urandom); end
         if ($urandom_range(0, 79) == 0) runstop = 1;
         tick();
      end

      // Asynchronous reset with words queued.
      trig = '0; holdoff = '0; trig_tready = 0;
      start_run(12'h0);
      write_mask(1'b0, 32'h0, 1);
      tick();
      trig = 48'h1;
      repeat (2) tick();
      trig = '0;
      repeat (5) tick();
      chk("pre_reset_tvalid", trig_tvalid, 1);
      gen_rst_i = 1;
      #1;
      model_reset();
      chk("async_rst_tvalid", trig_tvalid, 0);
      chk("async_rst_tdata", trig_tdata, 0);
      repeat (2) tick();
      gen_rst_i = 0;
      trig_tready = 1;
      pulse(48'h1, 3);
      chk("post_reset_idle", wq.size(), 0);
      update_mask();
      start_run(12'h0);
      pulse(48'hFFFF_FFFF_FFFF, 3);
      chk("post_reset_mask_ones", wq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
